// File: rtl/bcd2bin_seq.sv
// ============================================================================
// Module      : bcd2bin_seq
// Description : Sequential packed-BCD to binary converter (reverse double
//               dabble), one shift/correct iteration per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2bin_seq #(
    parameter int DIGITS = 6,
    parameter int BITS   = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BITS-1:0]       bin,
    output logic                  err,
    output logic                  ovf
);

    localparam int c_DW = 4 * DIGITS;
    localparam int c_CW = $clog2(BITS + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DW-1:0]     r_d;
    logic [BITS-1:0]     r_r;
    logic [c_CW-1:0]     r_cnt;
    logic                r_err_pend;

    logic [DIGITS-1:0]   w_dig_bad;
    logic                w_bad;
    logic [c_DW+BITS-1:0] w_cat;
    logic [c_DW-1:0]     w_d_sh;
    logic [c_DW-1:0]     w_d_fix;
    logic [BITS-1:0]     w_r_sh;
    logic                w_accept;
    logic                w_reject;
    logic                w_step;
    logic                w_last;

    assign w_cat  = {r_d, r_r} >> 1;
    assign w_d_sh = w_cat[c_DW+BITS-1:BITS];
    assign w_r_sh = w_cat[BITS-1:0];

    // Per-digit invalid check on the input and >=8 correction on the shifted digits
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign w_dig_bad[g]      = (bcd[4*g +: 4] > 4'd9);
        assign w_d_fix[4*g +: 4] = (w_d_sh[4*g +: 4] >= 4'd8) ? (w_d_sh[4*g +: 4] - 4'd3)
                                                               : w_d_sh[4*g +: 4];
    end

    assign w_bad = |w_dig_bad;
    assign busy  = (r_state == S_CONV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending error response blocks acceptance so done never overlaps busy
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !r_err_pend) begin
                    w_accept = 1'b1;
                    if (w_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_state_nxt = S_CONV;
                    end
                end
            end
            S_CONV: begin
                w_step = 1'b1;
                if (r_cnt == c_CW'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d        <= '0;
            r_r        <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            done       <= 1'b0;
            bin        <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done       <= 1'b0;
            r_err_pend <= w_reject;
            if (w_accept) begin
                r_d   <= bcd;
                r_r   <= '0;
                r_cnt <= c_CW'(BITS);
            end else if (w_step) begin
                r_d   <= w_d_fix;
                r_r   <= w_r_sh;
                r_cnt <= r_cnt - c_CW'(1);
            end
            if (w_last) begin
                done <= 1'b1;
                bin  <= w_r_sh;
                err  <= 1'b0;
                ovf  <= |w_d_fix;
            end else if (r_err_pend) begin
                done <= 1'b1;
                bin  <= '0;
                err  <= 1'b1;
                ovf  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
// ============================================================================
// Module      : tb_bcd2bin_seq
// Description : Scoreboard bench for bcd2bin_seq (default and 2-digit/6-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] bcd;
    logic        busy, done, err, ovf;
    logic [19:0] bin;

    logic        s_start;
    logic [7:0]  s_bcd;
    logic        s_busy, s_done, s_err, s_ovf;
    logic [5:0]  s_bin;

    typedef struct packed {
        logic [19:0] bin;
        logic        err;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bcd2bin_seq #(.DIGITS(6), .BITS(20)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
        .busy(busy), .done(done), .bin(bin), .err(err), .ovf(ovf)
    );

    bcd2bin_seq #(.DIGITS(2), .BITS(6)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .bcd(s_bcd),
        .busy(s_busy), .done(s_done), .bin(s_bin), .err(s_err), .ovf(s_ovf)
    );

    // Decimal reference: evaluate the digits as a number, then reduce to 'bits'
    function automatic exp_t ref_model(input logic [23:0] w, input int bits);
        longint v   = 0;
        logic   bad = 1'b0;
        exp_t   e;
        logic [3:0] d;
        for (int i = 5; i >= 0; i--) begin
            d = w[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            v = v * 10 + longint'(d);
        end
        e.err = bad;
        if (bad) begin
            e.bin = '0;
            e.ovf = 1'b0;
        end else begin
            e.bin = 20'(v % (longint'(1) << bits));
            e.ovf = (v >= (longint'(1) << bits));
        end
        return e;
    endfunction

    task automatic issue(input logic [23:0] w, input bit push);
        @(negedge clk);
        start = 1'b1;
        bcd   = w;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) exp_q.push_back(ref_model(w, 20));
    endtask

    task automatic wait_done(input int budget, output int lat, output bit seen);
        int t0;
        t0   = cyc;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        lat = cyc - t0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; bcd = '0; s_start = 1'b0; s_bcd = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({busy, done, bin, err, ovf} !== 24'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b bin=%0d err=%b ovf=%b, need all 0",
                     busy, done, bin, err, ovf);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_valid(input logic [23:0] w, input logic [19:0] want_bin);
        int lat; bit seen; exp_t e;
        issue(w, 1'b1);
        n_total++;
        if (busy !== 1'b1) $display("FAIL valid_busy %h: busy=%b need 1", w, busy);
        else n_pass++;
        wait_done(40, lat, seen);
        e = exp_q.pop_front();
        n_total++;
        if (!seen || lat != 20) $display("FAIL valid_latency %h: seen=%b lat=%0d need 20", w, seen, lat);
        else n_pass++;
        n_total++;
        if ({bin, err, ovf} !== e || bin !== want_bin)
            $display("FAIL valid_result %h: bin=%0d err=%b ovf=%b need bin=%0d err=%b ovf=%b",
                     w, bin, err, ovf, e.bin, e.err, e.ovf);
        else n_pass++;
    endtask

    task automatic test_invalid();
        int lat; bit seen; exp_t e;
        issue(24'h12A456, 1'b1);
        n_total++;
        if (busy !== 1'b0) $display("FAIL invalid_busy: busy=%b need 0", busy);
        else n_pass++;
        wait_done(5, lat, seen);
        e = exp_q.pop_front();
        n_total++;
        if (!seen || lat != 1 || busy !== 1'b0)
            $display("FAIL invalid_latency: seen=%b lat=%0d busy=%b need lat 1 busy 0", seen, lat, busy);
        else n_pass++;
        n_total++;
        if ({bin, err, ovf} !== e || err !== 1'b1)
            $display("FAIL invalid_result: bin=%0d err=%b ovf=%b need bin=0 err=1 ovf=0", bin, err, ovf);
        else n_pass++;
    endtask

    task automatic test_small();
        logic [7:0] words [2] = '{8'h99, 8'h63};
        exp_t e;
        bit   seen;
        int   lat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            s_start = 1'b1;
            s_bcd   = words[i];
            @(posedge clk); #1;
            s_start = 1'b0;
            exp_q.push_back(ref_model({16'h0, words[i]}, 6));
            seen = 1'b0;
            lat  = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(posedge clk); #1;
                lat++;
                if (s_done) seen = 1'b1;
            end
            e = exp_q.pop_front();
            n_total++;
            if (!seen || lat != 6 || s_bin !== e.bin[5:0] || s_ovf !== e.ovf || s_err !== 1'b0)
                $display("FAIL small_%h: seen=%b lat=%0d bin=%0d ovf=%b err=%b need lat 6 bin=%0d ovf=%b",
                         words[i], seen, lat, s_bin, s_ovf, s_err, e.bin[5:0], e.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit seen; exp_t e; int n_done;
        @(negedge clk);
        start = 1'b1;
        bcd   = 24'h000255;
        @(posedge clk); #1;
        exp_q.push_back(ref_model(24'h000255, 20));
        bcd = 24'h001024;
        wait_done(40, lat, seen);
        e = exp_q.pop_front();
        n_total++;
        if (!seen || lat != 20 || {bin, err, ovf} !== e)
            $display("FAIL b2b_first: seen=%b lat=%0d bin=%0d need lat 20 bin=%0d", seen, lat, bin, e.bin);
        else n_pass++;
        // start still high through the done cycle: second request accepted on the next edge
        exp_q.push_back(ref_model(24'h001024, 20));
        @(posedge clk); #1;
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept: busy=%b done=%b need busy 1 done 0", busy, done);
        else n_pass++;
        wait_done(40, lat, seen);
        e = exp_q.pop_front();
        n_total++;
        if (!seen || lat != 20 || {bin, err, ovf} !== e)
            $display("FAIL b2b_second: seen=%b lat=%0d bin=%0d need lat 20 bin=%0d", seen, lat, bin, e.bin);
        else n_pass++;

        issue(24'h000777, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        bcd   = 24'h000123;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, lat, seen);
        e = exp_q.pop_front();
        n_total++;
        if (!seen || {bin, err, ovf} !== e)
            $display("FAIL busy_ignore_result: seen=%b bin=%0d need %0d", seen, bin, e.bin);
        else n_pass++;
        n_done = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        n_total++;
        if (n_done != 0) $display("FAIL busy_ignore_extra: activity cycles=%0d need 0", n_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat; bit seen; int n_act;
        issue(24'h000500, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, bin, err, ovf} !== 24'd0)
            $display("FAIL reset_mid_outputs: busy=%b done=%b bin=%0d err=%b ovf=%b need all 0",
                     busy, done, bin, err, ovf);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n_act = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) n_act++;
        end
        n_total++;
        if (n_act != 0) $display("FAIL reset_mid_no_done: activity cycles=%0d need 0", n_act);
        else n_pass++;
        test_valid(24'h000042, 20'd42);
    endtask

    task automatic test_random();
        logic [23:0] w;
        int lat; bit seen; exp_t e;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 6; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
            issue(w, 1'b1);
            wait_done(40, lat, seen);
            e = exp_q.pop_front();
            n_total++;
            if (!seen || lat != 20 || {bin, err, ovf} !== e)
                $display("FAIL random_%h: seen=%b lat=%0d bin=%0d err=%b ovf=%b need bin=%0d",
                         w, seen, lat, bin, err, ovf, e.bin);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_valid(24'h000000, 20'd0);
        test_valid(24'h999999, 20'd999999);
        test_invalid();
        test_small();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
